pu_riscv_ram_1r1w_reader: RTL and testbench
===========================================

# pu_riscv_ram_1r1w_reader

Streaming read initiator for the inferred 1-read/1-write RAM macros. Accepts a (base, length) burst command, drives the RAM read address port, absorbs the RAM's fixed 1-cycle registered read latency, and presents the words as a valid/ready stream with a last marker. It sits between the RAM's read side and any consumer needing back-pressure: cache line refill, DMA, debug memory dump.

## Interface
Parameters:
- ABITS, 10, RAM address width; burst addresses wrap modulo 2**ABITS
- DBITS, 32, RAM/stream data width

Ports:
- clk_i  in  1  clock; all logic rising-edge
- rst_i  in  1  reset, synchronous, active-high
- start_i  in  1  command strobe; sampled only in IDLE
- base_i  in  ABITS  first word address
- len_i  in  ABITS+1  burst length in words, 0..2**ABITS
- busy_o  out  1  high from cycle after accepted start until done
- done_o  out  1  one-cycle pulse at burst completion
- raddr_o  out  ABITS  to RAM raddr_i
- rdata_i  in  DBITS  from RAM dout_o (valid 1 cycle after address)
- data_o  out  DBITS  stream data
- valid_o  out  1  stream valid
- ready_i  in  1  stream ready
- last_o  out  1  qualifies final word of burst (valid only with valid_o)

## Operation
- States: IDLE, RUN, DONE.
- IDLE: start_i=1 and len_i!=0 -> RUN; load addr counter=base_i, issue counter=len_i, deliver counter=len_i. start_i=1 and len_i=0 -> DONE (no data). start_i outside IDLE ignored.
- RUN: raddr_o = addr counter. A read is issued in a cycle when issue counter!=0 and occ + inflight - pop < 2, where occ = entries in 2-entry output buffer, inflight = read issued previous cycle (0/1), pop = valid_o & ready_i. On issue: addr counter +1 (wraps 2**ABITS-1 -> 0), issue counter -1, inflight set for next cycle.
- Cycle after issue: rdata_i written into output buffer (never overflows by the credit rule).
- Buffer is FIFO order; data_o/valid_o from head entry, registered (no combinational path rdata_i -> data_o, ready_i -> valid_o).
- Each pop decrements deliver counter; last_o = valid_o & (deliver counter==1).
- Deliver counter reaching 0 -> DONE. DONE: done_o=1 for one cycle, -> IDLE.
- busy_o = (state != IDLE).
- raddr_o holds last value when not issuing; RAM reads are side-effect free, unissued data is discarded.
- Reset (any state, mid-burst included): state IDLE, buffer emptied, inflight cleared, counters 0. Outputs after reset: busy_o 0, done_o 0, valid_o 0, last_o 0, data_o 0, raddr_o 0.

## Timing
- Start accepted at edge ending cycle T: busy_o=1 and first raddr_o=base_i in T+1; first word in buffer, valid_o=1 in T+3.
- ready_i held high: one word per cycle sustained; burst of N completes (last pop) in T+2+N; done_o in T+3+N; busy_o low in T+4+N; next start accepted in T+4+N.
- len_i=0: done_o in T+1, busy_o high only in T+1.
- ready_i low: at most 2 words buffered; issue halts; data_o/last_o stable while valid_o & !ready_i.
- Write/read same address collisions are the RAM's concern; reader returns whatever rdata_i holds.

## Configuration
- PU_RISCV_RAM_READER_ABORT_EN defined: adds input abort_i (1 bit). abort_i=1 in RUN -> next cycle buffer flushed, inflight discarded, valid_o=0, state DONE (done_o pulse), then IDLE; no last_o emitted. Ignored in IDLE/DONE. Reset has priority.
- Not defined: no abort_i port; a burst always runs to completion or reset.

## Test plan
- base=0x010, len=4, ready_i=1, RAM preloaded mem[a]=a: data 0x10,0x11,0x12,0x13 on consecutive cycles T+3..T+6, last_o only with 0x13, done_o at T+7.
- base=0x3FE, len=4 (ABITS=10): raddr_o sequence 0x3FE,0x3FF,0x000,0x001; data in same order.
- len=8, ready_i toggling 1,0,0,1 pseudo-random: all 8 words delivered in order, no loss/duplicate, data_o stable during stall, ≤2 outstanding+buffered.
- len=0: done_o pulse at T+1, valid_o never asserted; start_i pulsed while busy: ignored, burst unaffected.
- rst_i asserted mid-burst (after 3 of 8 words): next cycle all outputs at reset values; new start len=2 delivers correct 2 words.
- With PU_RISCV_RAM_READER_ABORT_EN: abort_i during len=16 burst with ready_i=0 and buffer full: valid_o 0 next cycle, done_o pulse, no last_o, next burst clean.

Source files
------------

// File: rtl/pu_riscv_ram_1r1w_reader.sv
// pu_riscv_ram_1r1w_reader
// Streaming read initiator for a 1-read/1-write RAM with 1-cycle registered
// read latency. Takes a (base, length) burst command, walks the RAM read
// address, and re-times the returned words into a 2-entry output buffer that
// drives a valid/ready stream with a last marker.
//
// Optional feature: define PU_RISCV_RAM_READER_ABORT_EN to add abort_i, which
// flushes an in-progress burst and finishes it through DONE without last_o.
module pu_riscv_ram_1r1w_reader #(
  parameter int ABITS = 10,
  parameter int DBITS = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [ABITS-1:0] base_i,
  input  logic [ABITS:0]   len_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [ABITS-1:0] raddr_o,
  input  logic [DBITS-1:0] rdata_i,
  output logic [DBITS-1:0] data_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             last_o
`ifdef PU_RISCV_RAM_READER_ABORT_EN
  ,
  input  logic             abort_i
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [ABITS-1:0] ADDR_ONE = {{(ABITS-1){1'b0}}, 1'b1};
  localparam logic [ABITS:0]   CNT_ONE  = {{ABITS{1'b0}}, 1'b1};
  localparam logic [ABITS:0]   CNT_ZERO = {(ABITS+1){1'b0}};

  state_t           state_r, state_nxt_s;
  logic [ABITS-1:0] addr_r, addr_nxt_s;
  logic [ABITS:0]   issue_cnt_r, issue_cnt_nxt_s;
  logic [ABITS:0]   deliver_cnt_r, deliver_cnt_nxt_s;
  logic             inflight_r, inflight_nxt_s;
  logic             head_vld_r, head_vld_nxt_s;
  logic [DBITS-1:0] head_dat_r, head_dat_nxt_s;
  logic             tail_vld_r, tail_vld_nxt_s;
  logic [DBITS-1:0] tail_dat_r, tail_dat_nxt_s;
  logic             busy_r, done_r, last_r;
  logic             last_nxt_s;
  logic             pop_s, credit_ok_s, issue_s, abort_s;

`ifdef PU_RISCV_RAM_READER_ABORT_EN
  assign abort_s = abort_i & (state_r == ST_RUN);
`else
  assign abort_s = 1'b0;
`endif

  // A word leaves the buffer when the head is valid and the consumer accepts it
  assign pop_s = head_vld_r & ready_i;

  // Credit: buffered + in-flight words, net of this cycle's pop, must leave room
  assign credit_ok_s = ({1'b0, head_vld_r} + {1'b0, tail_vld_r} + {1'b0, inflight_r})
                       < (2'd2 + {1'b0, pop_s});

  assign issue_s = (state_r == ST_RUN) && (issue_cnt_r != CNT_ZERO) && credit_ok_s && !abort_s;

  // Next-state, counter and output-buffer computation
  always_comb begin
    state_nxt_s       = state_r;
    addr_nxt_s        = addr_r;
    issue_cnt_nxt_s   = issue_cnt_r;
    deliver_cnt_nxt_s = deliver_cnt_r;
    inflight_nxt_s    = 1'b0;
    head_vld_nxt_s    = head_vld_r;
    head_dat_nxt_s    = head_dat_r;
    tail_vld_nxt_s    = tail_vld_r;
    tail_dat_nxt_s    = tail_dat_r;

    case (state_r)
      ST_IDLE: begin
        if (start_i) begin
          if (len_i != CNT_ZERO) begin
            state_nxt_s       = ST_RUN;
            addr_nxt_s        = base_i;
            issue_cnt_nxt_s   = len_i;
            deliver_cnt_nxt_s = len_i;
          end else begin
            state_nxt_s = ST_DONE;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (abort_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          if (issue_s) begin
            inflight_nxt_s  = 1'b1;
            issue_cnt_nxt_s = issue_cnt_r - CNT_ONE;
            // The final issued address stays on raddr_o after the burst
            if (issue_cnt_r != CNT_ONE) begin
              addr_nxt_s = addr_r + ADDR_ONE;
            end else begin
              addr_nxt_s = addr_r;
            end
          end else begin
            inflight_nxt_s = 1'b0;
          end
          if (pop_s) begin
            deliver_cnt_nxt_s = deliver_cnt_r - CNT_ONE;
            if (deliver_cnt_r == CNT_ONE) begin
              state_nxt_s = ST_DONE;
            end else begin
              state_nxt_s = ST_RUN;
            end
          end else begin
            state_nxt_s = ST_RUN;
          end
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase

    // Two-entry FIFO: head feeds the stream, tail catches the word behind it
    if (pop_s) begin
      if (tail_vld_r) begin
        head_vld_nxt_s = 1'b1;
        head_dat_nxt_s = tail_dat_r;
        tail_vld_nxt_s = inflight_r;
        if (inflight_r) begin
          tail_dat_nxt_s = rdata_i;
        end else begin
          tail_dat_nxt_s = tail_dat_r;
        end
      end else begin
        head_vld_nxt_s = inflight_r;
        if (inflight_r) begin
          head_dat_nxt_s = rdata_i;
        end else begin
          head_dat_nxt_s = head_dat_r;
        end
      end
    end else if (inflight_r) begin
      if (head_vld_r) begin
        tail_vld_nxt_s = 1'b1;
        tail_dat_nxt_s = rdata_i;
      end else begin
        head_vld_nxt_s = 1'b1;
        head_dat_nxt_s = rdata_i;
      end
    end else begin
      head_vld_nxt_s = head_vld_r;
      tail_vld_nxt_s = tail_vld_r;
    end

    // Abort drops everything buffered or still returning from the RAM
    if (abort_s) begin
      head_vld_nxt_s = 1'b0;
      tail_vld_nxt_s = 1'b0;
      inflight_nxt_s = 1'b0;
    end else begin
      inflight_nxt_s = inflight_nxt_s;
    end

    last_nxt_s = head_vld_nxt_s && (deliver_cnt_nxt_s == CNT_ONE);
  end

  // State, counters, buffer and registered outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r       <= ST_IDLE;
      addr_r        <= {ABITS{1'b0}};
      issue_cnt_r   <= CNT_ZERO;
      deliver_cnt_r <= CNT_ZERO;
      inflight_r    <= 1'b0;
      head_vld_r    <= 1'b0;
      head_dat_r    <= {DBITS{1'b0}};
      tail_vld_r    <= 1'b0;
      tail_dat_r    <= {DBITS{1'b0}};
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      last_r        <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      addr_r        <= addr_nxt_s;
      issue_cnt_r   <= issue_cnt_nxt_s;
      deliver_cnt_r <= deliver_cnt_nxt_s;
      inflight_r    <= inflight_nxt_s;
      head_vld_r    <= head_vld_nxt_s;
      head_dat_r    <= head_dat_nxt_s;
      tail_vld_r    <= tail_vld_nxt_s;
      tail_dat_r    <= tail_dat_nxt_s;
      busy_r        <= (state_nxt_s != ST_IDLE);
      done_r        <= (state_nxt_s == ST_DONE);
      last_r        <= last_nxt_s;
    end
  end

  assign busy_o  = busy_r;
  assign done_o  = done_r;
  assign raddr_o = addr_r;
  assign data_o  = head_dat_r;
  assign valid_o = head_vld_r;
  assign last_o  = last_r;

endmodule

// File: tb/tb_pu_riscv_ram_1r1w_reader.sv
// Testbench for pu_riscv_ram_1r1w_reader: directed bursts against a behavioural
// RAM holding mem[a] = a; a scoreboard queue receives the expected words when a
// burst is started and a negedge monitor pops and compares on every handshake.
module tb_pu_riscv_ram_1r1w_reader;
  localparam int ABITS = 10;
  localparam int DBITS = 32;

  logic             clk = 1'b0;
  logic             rst, start, ready;
  logic [ABITS-1:0] base;
  logic [ABITS:0]   len;
  logic             busy, done, valid, last;
  logic [ABITS-1:0] raddr;
  logic [DBITS-1:0] rdata, data;
`ifdef PU_RISCV_RAM_READER_ABORT_EN
  logic             abort = 1'b0;
`endif

  typedef struct packed {
    logic [DBITS-1:0] d;
    logic             l;
  } exp_t;

  exp_t             exp_q[$];
  int               pass_cnt = 0;
  int               chk_cnt  = 0;
  logic [ABITS-1:0] raddr_log [1:4];
  logic             pat [0:7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
  logic             prev_stall = 1'b0;
  logic [DBITS-1:0] prev_data  = '0;
  logic             prev_last  = 1'b0;
  int               done_k, fv_k;

  pu_riscv_ram_1r1w_reader #(.ABITS(ABITS), .DBITS(DBITS)) dut (
`ifdef PU_RISCV_RAM_READER_ABORT_EN
    .abort_i (abort),
`endif
    .clk_i   (clk),
    .rst_i   (rst),
    .start_i (start),
    .base_i  (base),
    .len_i   (len),
    .busy_o  (busy),
    .done_o  (done),
    .raddr_o (raddr),
    .rdata_i (rdata),
    .data_o  (data),
    .valid_o (valid),
    .ready_i (ready),
    .last_o  (last)
  );

  always #5 clk = ~clk;

  function automatic logic [DBITS-1:0] ram_word(input logic [ABITS-1:0] a);
    ram_word = {{(DBITS-ABITS){1'b0}}, a};
  endfunction

  // Behavioural RAM read port with 1-cycle registered latency
  always @(posedge clk) rdata <= ram_word(raddr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    chk_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
  endtask

  // Scoreboard monitor: compare every accepted word, check stall stability
  always @(negedge clk) begin
    if (prev_stall && valid) begin
      check("stall_data", data, prev_data);
      check("stall_last", {31'd0, last}, {31'd0, prev_last});
    end
    if (valid && ready && !rst) begin
      if (exp_q.size() == 0) begin
        chk_cnt++;
        $display("FAIL unexpected_word: got 0x%0h with nothing expected", data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("data", data, e.d);
        check("last", {31'd0, last}, {31'd0, e.l});
      end
    end
    prev_stall = valid && !ready && !rst;
    prev_data  = data;
    prev_last  = last;
  end

  // Drive one start strobe; returns one tick into cycle T+1
  task automatic start_burst(input logic [ABITS-1:0] b, input int l);
    @(posedge clk); #1;
    start = 1'b1;
    base  = b;
    len   = (ABITS+1)'(l);
    for (int i = 0; i < l; i++)
      exp_q.push_back('{d: ram_word(b + ABITS'(i)), l: (i == l - 1)});
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Walk the burst cycle by cycle (k = cycles after T) until done_o
  task automatic run_burst(input int max_cyc, input bit toggle, input bit poke,
                           output int dk, output int fvk);
    dk  = -1;
    fvk = -1;
    for (int k = 1; k <= max_cyc; k++) begin
      @(negedge clk);
      if (valid && fvk < 0) fvk = k;
      if (k <= 4) raddr_log[k] = raddr;
      if (done) begin
        dk = k;
        break;
      end
      @(posedge clk); #1;
      if (toggle) ready = pat[k % 8];
      if (poke && k == 2) begin
        start = 1'b1;
        len   = 11'd3;
      end else begin
        start = 1'b0;
      end
    end
    if (dk < 0) begin
      chk_cnt++;
      $display("FAIL done_timeout: got no done_o within %0d cycles", max_cyc);
    end
    ready = 1'b1;
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; base = '0; len = '0; ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_busy",  {31'd0, busy},  32'd0);
    check("rst_done",  {31'd0, done},  32'd0);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_raddr", {22'd0, raddr}, 32'd0);
    check("rst_data",  data,           32'd0);

    // Basic burst, stray start while busy must be ignored
    start_burst(10'h010, 4);
    check("t1_busy",  {31'd0, busy},  32'd1);
    check("t1_raddr", {22'd0, raddr}, 32'h010);
    run_burst(40, 1'b0, 1'b1, done_k, fv_k);
    check("t1_first_valid", 32'(fv_k),   32'd3);
    check("t1_done_cycle",  32'(done_k), 32'd7);
    @(posedge clk); #1;
    check("t1_busy_low", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    check("t1_stray_start_ignored", {31'd0, busy}, 32'd0);

    // Address wrap at the top of the RAM
    start_burst(10'h3FE, 4);
    run_burst(40, 1'b0, 1'b0, done_k, fv_k);
    check("t2_raddr1", {22'd0, raddr_log[1]}, 32'h3FE);
    check("t2_raddr2", {22'd0, raddr_log[2]}, 32'h3FF);
    check("t2_raddr3", {22'd0, raddr_log[3]}, 32'h000);
    check("t2_raddr4", {22'd0, raddr_log[4]}, 32'h001);
    check("t2_done_cycle", 32'(done_k), 32'd7);

    // Back-pressure with a toggling ready pattern
    start_burst(10'h100, 8);
    run_burst(80, 1'b1, 1'b0, done_k, fv_k);
    check("t3_queue_drained", 32'(exp_q.size()), 32'd0);

    // Zero-length burst
    start_burst(10'h055, 0);
    check("t4_done",  {31'd0, done},  32'd1);
    check("t4_busy",  {31'd0, busy},  32'd1);
    check("t4_valid", {31'd0, valid}, 32'd0);
    @(posedge clk); #1;
    check("t4_busy_low", {31'd0, busy}, 32'd0);
    check("t4_done_low", {31'd0, done}, 32'd0);

    // Reset in the middle of a burst after three words
    start_burst(10'h200, 8);
    repeat (5) begin
      @(posedge clk); #1;
    end
    ready = 1'b0;
    rst   = 1'b1;
    @(posedge clk); #1;
    check("t5_busy",  {31'd0, busy},  32'd0);
    check("t5_done",  {31'd0, done},  32'd0);
    check("t5_valid", {31'd0, valid}, 32'd0);
    check("t5_last",  {31'd0, last},  32'd0);
    check("t5_data",  data,           32'd0);
    check("t5_raddr", {22'd0, raddr}, 32'd0);
    check("t5_words_left", 32'(exp_q.size()), 32'd5);
    exp_q.delete();
    rst   = 1'b0;
    ready = 1'b1;
    start_burst(10'h005, 2);
    run_burst(40, 1'b0, 1'b0, done_k, fv_k);
    check("t5_restart_done_cycle", 32'(done_k), 32'd5);

`ifdef PU_RISCV_RAM_READER_ABORT_EN
    // Abort with a full buffer under back-pressure
    @(posedge clk); #1;
    ready = 1'b0;
    start_burst(10'h040, 16);
    repeat (5) begin
      @(posedge clk); #1;
    end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("ab_valid", {31'd0, valid}, 32'd0);
    check("ab_done",  {31'd0, done},  32'd1);
    check("ab_last",  {31'd0, last},  32'd0);
    @(posedge clk); #1;
    check("ab_busy_low", {31'd0, busy}, 32'd0);
    exp_q.delete();
    ready = 1'b1;
    start_burst(10'h3FF, 2);
    run_burst(40, 1'b0, 1'b0, done_k, fv_k);
    check("ab_next_done_cycle", 32'(done_k), 32'd5);
`endif

    repeat (3) @(posedge clk);
    #1;
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
